// File: rtl/leb128_pkg.sv
// Shared LEB128 definitions: byte-count and length-width helpers, state enum, glue bit.
// Common to the parallel unpacker, the streaming decoder and the encoder.
package leb128_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    SKIP = 1'b1
  } leb_state_e;

  localparam int GLUE_BIT = 7;

  function automatic int leb128_max_bytes(input int width);
    return (width + 6) / 7;
  endfunction

  function automatic int leb128_len_w(input int width);
    return $clog2(leb128_max_bytes(width) + 1);
  endfunction

endpackage

// File: rtl/leb128_out_slot.sv
// Single-entry valid/ready output register carrying a decoded word, its length and error flag.
// A new word may be loaded in the same cycle the held word is popped.
module leb128_out_slot
  import leb128_pkg::*;
#(
  parameter int W     = 64,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_load,
  input  logic [W-1:0]     i_data,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_err,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [W-1:0]     o_data,
  output logic [LEN_W-1:0] o_len,
  output logic             o_err
);

  logic             r_valid;
  logic [W-1:0]     r_data;
  logic [LEN_W-1:0] r_len;
  logic             r_err;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_len   <= '0;
      r_err   <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_len   <= i_len;
      r_err   <= i_err;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_len   = r_len;
  assign o_err   = r_err;

endmodule

// File: rtl/leb128_dec_stream.sv
// Byte-serial LEB128 decoder: accumulates 7-bit chunks into a W-bit word, flags overflow/overrun.
// Define LEB128_SIGNED_EN to add the in_signed port and SLEB128 sign extension.
//
// state | meaning
// ACC   | accumulating chunks of the current value; r_idx = bytes already taken
// SKIP  | after an overrun, discarding bytes up to and including the next terminal byte
module leb128_dec_stream
  import leb128_pkg::*;
#(
  parameter  int W         = 64,
  localparam int MAX_BYTES = leb128_max_bytes(W),
  localparam int LEN_W     = leb128_len_w(W)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
`ifdef LEB128_SIGNED_EN
  input  logic             in_signed,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [LEN_W-1:0] out_len,
  output logic             out_err
);

  localparam int EXT_W = 7 * MAX_BYTES;

  leb_state_e       r_state;
  logic [LEN_W-1:0] r_idx;
  logic [W-1:0]     r_acc;
`ifdef LEB128_SIGNED_EN
  logic             r_signed;
`endif

  logic [6:0]       w_chunk;
  logic             w_glue;
  logic [EXT_W-1:0] w_shift;
  logic [W-1:0]     w_merged;
  logic [7:0]       w_bitpos;
  logic [W-1:0]     w_fill;
  logic [W-1:0]     w_word;
  logic             w_sgn_val;
  logic             w_ovf;
  logic             w_last;
  logic             w_acc_state;
  logic             w_accept;
  logic             w_load;
  logic [W-1:0]     w_load_data;
  logic [LEN_W-1:0] w_load_len;
  logic             w_load_err;

  always_comb begin
    w_chunk  = in_data[6:0];
    w_glue   = in_data[GLUE_BIT];
    w_shift  = EXT_W'(w_chunk) << (7 * r_idx);
    w_merged = r_acc | w_shift[W-1:0];
    w_bitpos = 8'(7 * (int'(r_idx) + 1));
    w_fill   = {W{1'b1}} << w_bitpos;
`ifdef LEB128_SIGNED_EN
    w_sgn_val = (r_idx == '0) ? in_signed : r_signed;
`else
    w_sgn_val = 1'b0;
`endif
    w_word = (w_sgn_val & w_chunk[6]) ? (w_merged | w_fill) : w_merged;
    // Encoded bits above W must be zero (unsigned) or copies of the result sign (signed).
    w_ovf = 1'b0;
    for (int j = W; j < EXT_W; j++) begin
      if (j < int'(w_bitpos)) begin
        w_ovf = w_ovf | (w_sgn_val ? (w_shift[j] != w_word[W-1]) : w_shift[j]);
      end
    end
  end

  assign w_last      = (r_idx == LEN_W'(MAX_BYTES - 1));
  assign w_acc_state = (r_state == ACC);
  assign in_ready    = !w_acc_state | !out_valid | out_ready;
  assign w_accept    = in_valid & in_ready;
  assign w_load      = w_accept & w_acc_state & (!w_glue | w_last);
  // An overrun word carries the raw truncated chunks, never sign fill.
  assign w_load_data = w_glue ? w_merged : w_word;
  assign w_load_len  = r_idx + 1'b1;
  assign w_load_err  = w_glue | w_ovf;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= ACC;
      r_idx    <= '0;
      r_acc    <= '0;
`ifdef LEB128_SIGNED_EN
      r_signed <= 1'b0;
`endif
    end else if (w_accept) begin
      case (r_state)
        ACC: begin
`ifdef LEB128_SIGNED_EN
          r_signed <= w_sgn_val;
`endif
          if (!w_glue) begin
            r_idx <= '0;
            r_acc <= '0;
          end else if (w_last) begin
            r_idx   <= '0;
            r_acc   <= '0;
            r_state <= SKIP;
          end else begin
            r_idx <= r_idx + 1'b1;
            r_acc <= w_merged;
          end
        end
        SKIP: begin
          if (!w_glue) r_state <= ACC;
        end
        default: r_state <= ACC;
      endcase
    end
  end

  leb128_out_slot #(
    .W     (W),
    .LEN_W (LEN_W)
  ) u_out_slot (
    .clk     (clk),
    .rstn    (rstn),
    .i_load  (w_load),
    .i_data  (w_load_data),
    .i_len   (w_load_len),
    .i_err   (w_load_err),
    .i_ready (out_ready),
    .o_valid (out_valid),
    .o_data  (out_data),
    .o_len   (out_len),
    .o_err   (out_err)
  );

endmodule

// File: tb/tb_leb128_dec_stream.sv
// Scoreboard bench for leb128_dec_stream: directed cases plus randomized byte streams
// checked against an arithmetic LEB128 reference model.
module tb_leb128_dec_stream;
  import leb128_pkg::*;

  localparam int W     = 64;
  localparam int MAXB  = leb128_max_bytes(W);
  localparam int LEN_W = leb128_len_w(W);
`ifdef LEB128_SIGNED_EN
  localparam bit SGN_BUILD = 1'b1;
`else
  localparam bit SGN_BUILD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       in_data = 8'h00;
  logic             cur_sgn = 1'b0;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic [LEN_W-1:0] out_len;
  logic             out_err;

  leb128_dec_stream #(.W(W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef LEB128_SIGNED_EN
    .in_signed (cur_sgn),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_len   (out_len),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]     data;
    logic [LEN_W-1:0] len;
    logic             err;
  } word_t;

  word_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  bit rand_mode = 1'b0;
  bit ready_force = 1'b1;

  // Reference model: integer value of the chunks, range-checked against W bits.
  logic [127:0] m_sum;
  int           m_n;
  bit           m_skip;
  bit           m_sgn;

  function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h, required %0h", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    m_sum  = '0;
    m_n    = 0;
    m_skip = 1'b0;
    m_sgn  = 1'b0;
  endfunction

  function automatic void model_byte(input logic [7:0] b, input bit sgn);
    logic [127:0] val;
    logic [127:0] hi;
    bit           err;
    word_t        w;
    if (m_skip) begin
      if (!b[7]) m_skip = 1'b0;
      return;
    end
    if (m_n == 0) m_sgn = sgn;
    m_sum = m_sum + (128'(b[6:0]) << (7 * m_n));
    m_n++;
    if (!b[7]) begin
      val = m_sum;
      if (m_sgn && b[6]) val = m_sum - (128'd1 << (7 * m_n));
      hi = val >> (W - 1);
      if (m_sgn) err = !(hi == '0 || hi == ({128{1'b1}} >> (W - 1)));
      else       err = (val >> W) != '0;
      w.data = val[W-1:0];
      w.len  = LEN_W'(m_n);
      w.err  = err;
      exp_q.push_back(w);
      m_sum = '0;
      m_n   = 0;
    end else if (m_n == MAXB) begin
      w.data = m_sum[W-1:0];
      w.len  = LEN_W'(MAXB);
      w.err  = 1'b1;
      exp_q.push_back(w);
      m_skip = 1'b1;
      m_sum  = '0;
      m_n    = 0;
    end
  endfunction

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      out_ready = rand_mode ? ($urandom_range(0, 3) != 0) : ready_force;
    end
  end

  initial begin
    word_t e;
    forever begin
      @(negedge clk);
      if (rstn && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_word: actual data %0h len %0d err %0b, required no word",
                   out_data, out_len, out_err);
        end else begin
          e = exp_q.pop_front();
          check("word_data", 128'(out_data), 128'(e.data));
          check("word_len", 128'(out_len), 128'(e.len));
          check("word_err", 128'(out_err), 128'(e.err));
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit chk_rdy);
    int waited = 0;
    bit first = 1'b1;
    in_valid = 1'b1;
    in_data  = b;
    forever begin
      @(negedge clk);
      if (first && chk_rdy) check("in_ready_streaming", 128'(in_ready), 128'd1);
      first = 1'b0;
      if (in_ready) break;
      waited++;
      if (waited > 200) begin
        n_tests++;
        n_fail++;
        $display("FAIL accept_timeout: byte %02h not accepted, required acceptance within 200 cycles", b);
        in_valid = 1'b0;
        return;
      end
    end
    model_byte(b, cur_sgn);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while (exp_q.size() != 0 && k < 1000) begin
      @(posedge clk);
      k++;
    end
    @(posedge clk);
    #1;
    check({"drain_", tag}, 128'(exp_q.size()), 128'd0);
  endtask

  initial begin
    int len;
    logic [6:0] ch;
    logic [7:0] bt;

    model_reset();
    #12;
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_out_data", 128'(out_data), 128'd0);
    check("rst_out_len", 128'(out_len), 128'd0);
    check("rst_out_err", 128'(out_err), 128'd0);
    check("rst_in_ready", 128'(in_ready), 128'd1);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    send_byte(8'hE5, 1'b0);
    send_byte(8'h8E, 1'b0);
    send_byte(8'h26, 1'b0);
    check("latency_out_valid", 128'(out_valid), 128'd1);
    drain("three_byte");

    send_byte(8'h7F, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h80, 1'b1);
    send_byte(8'h01, 1'b1);
    drain("stream");

    for (int i = 0; i < 9; i++) send_byte(8'hFF, 1'b0);
    send_byte(8'h01, 1'b0);
    for (int i = 0; i < 9; i++) send_byte(8'hFF, 1'b0);
    send_byte(8'h03, 1'b0);
    drain("max_len");

    for (int i = 0; i < 11; i++) send_byte(8'h80, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h2A, 1'b0);
    drain("overrun");

    ready_force = 1'b0;
    send_byte(8'h05, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h7F;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", 128'(in_ready), 128'd0);
      check("stall_out_valid", 128'(out_valid), 128'd1);
      check("stall_out_data", 128'(out_data), 128'd5);
      check("stall_out_len", 128'(out_len), 128'd1);
      @(posedge clk);
      #1;
    end
    ready_force = 1'b1;
    send_byte(8'h7F, 1'b0);
    send_byte(8'h01, 1'b0);
    drain("stall");

    cur_sgn = SGN_BUILD;
    send_byte(8'h7F, 1'b0);
    send_byte(8'hC0, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'h78, 1'b0);
    drain("signed_or_plain");

    send_byte(8'hC0, 1'b0);
    rstn = 1'b0;
    model_reset();
    #3;
    check("midrst_out_valid", 128'(out_valid), 128'd0);
    check("midrst_in_ready", 128'(in_ready), 128'd1);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    send_byte(8'h05, 1'b0);
    drain("mid_reset");

    rand_mode = 1'b1;
    for (int v = 0; v < 300; v++) begin
      len = $urandom_range(1, MAXB + 2);
      cur_sgn = SGN_BUILD ? 1'($urandom_range(0, 1)) : 1'b0;
      for (int i = 0; i < len; i++) begin
        case ($urandom_range(0, 3))
          0:       ch = 7'h00;
          1:       ch = 7'h7F;
          2:       ch = 7'h01;
          default: ch = 7'($urandom);
        endcase
        bt = {1'(i < len - 1), ch};
        send_byte(bt, 1'b0);
        if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
      end
    end
    rand_mode   = 1'b0;
    ready_force = 1'b1;
    send_byte(8'h00, 1'b0);
    drain("random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time limit, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/leb128_dec_stream.md
Name: leb128_dec_stream

Overview:
- Byte-serial streaming LEB128 decoder; successor to the parallel 10-byte unsigned unpacker.
- Accepts one encoded byte per cycle over a valid/ready handshake and accumulates 7-bit chunks into a W-bit value.
- Emits the decoded value, its byte length and an error flag through a registered valid/ready output slot.
- Sits between the byte-stream front end (bitstream parser) and field consumers; generalised in output width, with detection and resynchronisation on overlong or overflowing encodings.

Parameters:
- W, 64, decoded value width in bits; legal range 8..64.
- MAX_BYTES, (W+6)/7, maximum encoded bytes per value; derived, not overridden.
- LEN_W, $clog2(MAX_BYTES+1), width of the len field.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- in_valid  in  1  input byte valid.
- in_ready  out  1  input byte accepted when in_valid & in_ready.
- in_data  in  8  encoded byte; bit 7 is the continuation (glue) bit, bits 6:0 are the chunk.
- out_valid  out  1  decoded word valid.
- out_ready  in  1  consumer accepts the word when out_valid & out_ready.
- out_data  out  W  decoded value, zero-extended.
- out_len  out  LEN_W  number of bytes consumed for this value, 1..MAX_BYTES.
- out_err  out  1  encoding overrun or overflow.

Behaviour:
- Reset (async, rstn=0): state=ACC, idx=0, acc=0, out_valid=0, out_data=0, out_len=0, out_err=0.
- in_ready = (state==SKIP) | !out_valid | out_ready. One byte per cycle sustained; no bubbles.
- ACC state, on each accepted byte:
  - acc[7*idx +: 7] <= chunk; bits beyond W are dropped.
  - idx increments by 1.
  - Chunks at positions above idx are already zero, so short values need no masking. acc is cleared when a value completes.
- Terminal byte (bit7=0) at idx<MAX_BYTES:
  - Next cycle: out_valid=1, out_data=acc with the final chunk merged, out_len=idx+1.
  - out_err=1 if any dropped chunk bit was 1 (overflow); for W=64 this means byte 9 bits 6:1 nonzero.
  - idx then returns to 0.
- Overrun (bit7=1 at idx==MAX_BYTES-1):
  - Emit a word next cycle with out_err=1, out_len=MAX_BYTES and the truncated out_data.
  - Go to SKIP.
- SKIP state:
  - Accept and discard bytes unconditionally.
  - The first byte with bit7=0 returns the block to ACC with idx=0; no word is emitted for the discarded bytes.
- Output slot: holds until out_ready. A new word is written in the same cycle the old word is popped.
  - If out_valid & !out_ready, in_ready=0 in ACC, so no byte is lost.
  - Exception: the overrun byte while the slot is full stalls like any other byte.
- Latency: terminal byte accepted at cycle N gives out_valid at N+1.
- Reset mid-value discards the partial accumulation; the next byte starts a new value.

Optional Feature:
- Macro LEB128_SIGNED_EN.
- Defined:
  - Adds input port in_signed (1 bit), sampled with the first byte of each value.
  - Signed values are SLEB128: after the terminal chunk, out_data bits above 7*(idx+1) are filled with bit 6 of the terminal chunk.
  - Overflow is flagged when dropped bits differ from the resulting sign bit rather than when they are nonzero.
- Undefined: port absent; unsigned-only behaviour as above.

Decomposition:
- Package leb128_pkg:
  - Function leb128_max_bytes(width) and the LEN_W derivation.
  - State enum {ACC, SKIP}.
  - Constant GLUE_BIT=7.
  - Shared with the existing parallel unpacker and the future encoder.
- One sub-module, leb128_out_slot: single-entry valid/ready output register (data, len, err), reused by the encoder.

Test Plan:
- Bytes 0xE5,0x8E,0x26 back-to-back, out_ready=1 → one word at the cycle after 0x26: out_data=624485, out_len=3, out_err=0.
- 0x7F,0x00,0x80,0x01 streamed continuously → words 127/len1, 0/len1, 128/len2; in_ready held 1 throughout.
- Nine 0xFF then 0x01 (W=64) → 0xFFFF_FFFF_FFFF_FFFF, len 10, err 0; repeat with last byte 0x03 → err=1.
- Eleven 0x80 then 0x05, then 0x2A → err word (len 10) after byte 10; byte 11 and 0x05 are discarded; then 42/len1.
- out_ready=0 for 5 cycles with word pending and 0x7F,0x01 offered → in_ready=0 and the word is stable; on release the words arrive in order 0x7F, then 1.
- LEB128_SIGNED_EN, in_signed=1: 0x7F → all-ones (-1); 0xC0,0xBB,0x78 → -123456, len3. Assert rstn mid-sequence after 0xC0 → 0x05 decodes to 5, len1.
